// File: rtl/odd_parity_checker.sv
// Receive-side odd-parity checker: registers per-word parity/error flags,
// accumulates parity across a frame and keeps saturating word/error counts.
module odd_parity_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             clr,
    output logic             out,
    output logic             out_valid,
    output logic             word_err,
    output logic             frame_par,
    output logic             frame_valid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [3:0] data;
        logic       valid;
        logic       last;
    } req_t;

    req_t req;
    logic par;
    logic acc;
    logic word_sat;
    logic err_sat;

    assign req      = '{data: {a, b, c, d}, valid: in_valid, last: in_last};
    assign par      = ^req.data;
    assign word_sat = &word_cnt;
    assign err_sat  = &err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out         <= 1'b0;
            out_valid   <= 1'b0;
            word_err    <= 1'b0;
            frame_par   <= 1'b0;
            frame_valid <= 1'b0;
            err_sticky  <= 1'b0;
            acc         <= 1'b0;
            word_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            out_valid   <= req.valid;
            word_err    <= req.valid & ~par;
            frame_valid <= req.valid & req.last;
            if (req.valid) begin
                out <= par;
                // Last word closes the frame; acc restarts at 0 for the next one.
                if (req.last) begin
                    frame_par <= acc ^ par;
                    acc       <= 1'b0;
                end else begin
                    acc <= acc ^ par;
                end
            end

            // clr wins over a word accepted in the same cycle.
            if (clr) begin
                word_cnt   <= '0;
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end else if (req.valid) begin
                if (!word_sat)
                    word_cnt <= word_cnt + CNT_W'(1);
                if (!par) begin
                    err_sticky <= 1'b1;
                    if (!err_sat)
                        err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_odd_parity_checker.sv
// Bench for odd_parity_checker: two instances (CNT_W = 8 and 4) share stimulus
// and are compared every cycle against a count-of-ones reference model.
module tb_odd_parity_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, clr = 1'b0;

    logic       out8, ov8, we8, fp8, fv8, st8;
    logic [7:0] wc8, ec8;
    logic       out4, ov4, we4, fp4, fv4, st4;
    logic [3:0] wc4, ec4;

    int total = 0;
    int passed = 0;

    // reference model state
    bit m_out, m_ov, m_we, m_fp, m_fv, m_st, m_acc;
    int m_wc, m_ec;

    typedef struct {
        logic [3:0] w;
        logic       exp_out;
    } vec_t;
    vec_t tbl [16];

    odd_parity_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_last(in_last), .clr(clr),
        .out(out8), .out_valid(ov8), .word_err(we8), .frame_par(fp8),
        .frame_valid(fv8), .err_sticky(st8), .word_cnt(wc8), .err_cnt(ec8)
    );

    odd_parity_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_last(in_last), .clr(clr),
        .out(out4), .out_valid(ov4), .word_err(we4), .frame_par(fp4),
        .frame_valid(fv4), .err_sticky(st4), .word_cnt(wc4), .err_cnt(ec4)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_model();
        chk("out", int'(out8), int'(m_out));
        chk("out_valid", int'(ov8), int'(m_ov));
        chk("word_err", int'(we8), int'(m_we));
        chk("frame_par", int'(fp8), int'(m_fp));
        chk("frame_valid", int'(fv8), int'(m_fv));
        chk("err_sticky", int'(st8), int'(m_st));
        chk("word_cnt8", int'(wc8), sat(m_wc, 8));
        chk("err_cnt8", int'(ec8), sat(m_ec, 8));
        chk("word_cnt4", int'(wc4), sat(m_wc, 4));
        chk("err_cnt4", int'(ec4), sat(m_ec, 4));
        chk("out4", int'(out4), int'(m_out));
        chk("frame_par4", int'(fp4), int'(m_fp));
    endtask

    // Drive one cycle (from a negedge), update the model at the edge, check at the next negedge.
    task automatic cycle(input bit rn, input bit v, input bit l, input bit cl, input logic [3:0] w);
        bit p;
        rst_n = rn; in_valid = v; in_last = l; clr = cl;
        {a, b, c, d} = w;
        @(posedge clk);
        p = ($countones(w) % 2) == 1;
        if (!rn) begin
            {m_out, m_ov, m_we, m_fp, m_fv, m_st, m_acc} = '0;
            m_wc = 0; m_ec = 0;
        end else begin
            m_ov = v;
            m_we = v && !p;
            m_fv = v && l;
            if (v) m_out = p;
            if (v && l) begin
                m_fp = m_acc ^ p;
                m_acc = 1'b0;
            end else if (v) begin
                m_acc = m_acc ^ p;
            end
            if (cl) begin
                m_wc = 0; m_ec = 0; m_st = 1'b0;
            end else if (v) begin
                m_wc++;
                if (!p) begin
                    m_ec++;
                    m_st = 1'b1;
                end
            end
        end
        @(negedge clk);
        chk_model();
    endtask

    initial begin
        bit exp_seq [16] = '{0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0};
        for (int i = 0; i < 16; i++) begin
            tbl[i].w = 4'(i);
            tbl[i].exp_out = exp_seq[i];
        end

        // reset state
        cycle(0, 0, 0, 0, 4'h0);
        chk("rst_out", int'(out8), 0);
        chk("rst_word_cnt", int'(wc8), 0);

        // exhaustive sweep against the table
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, 0, tbl[i].w);
            chk($sformatf("tbl_out_%0d", i), int'(out8), int'(tbl[i].exp_out));
            chk($sformatf("tbl_err_%0d", i), int'(we8), int'(!tbl[i].exp_out));
        end
        chk("sweep_word_cnt", int'(wc8), 16);
        chk("sweep_err_cnt", int'(ec8), 8);
        chk("sweep_sticky", int'(st8), 1);

        // reset held with a valid word present
        cycle(0, 1, 0, 0, 4'b0001);
        cycle(0, 1, 0, 0, 4'b0001);
        chk("rst_hold_ov", int'(ov8), 0);
        chk("rst_hold_wc", int'(wc8), 0);
        chk("rst_hold_st", int'(st8), 0);
        cycle(1, 1, 1, 0, 4'b0111);
        chk("post_rst_out", int'(out8), 1);
        chk("post_rst_err", int'(we8), 0);

        // three-word frame then single-word frame
        cycle(1, 1, 0, 0, 4'b0001);
        chk("frame_mid_fv", int'(fv8), 0);
        cycle(1, 1, 0, 0, 4'b0011);
        cycle(1, 1, 1, 0, 4'b0111);
        chk("frame3_fv", int'(fv8), 1);
        chk("frame3_fp", int'(fp8), 0);
        cycle(1, 1, 1, 0, 4'b1000);
        chk("frame1_fv", int'(fv8), 1);
        chk("frame1_fp", int'(fp8), 1);
        cycle(1, 0, 1, 0, 4'b1000);
        chk("last_no_valid_fv", int'(fv8), 0);

        // saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 4'b0000);
        chk("sat_wc4", int'(wc4), 15);
        chk("sat_ec4", int'(ec4), 15);

        // clr colliding with an even-parity word
        cycle(1, 1, 0, 1, 4'b0000);
        chk("clr_ec", int'(ec8), 0);
        chk("clr_wc", int'(wc8), 0);
        chk("clr_st", int'(st8), 0);
        chk("clr_we", int'(we8), 1);
        chk("clr_ov", int'(ov8), 1);

        // idle gaps with 1111
        for (int i = 0; i < 6; i++) begin
            cycle(1, (i % 2) == 0, 0, 0, 4'b1111);
            chk("gap_ov", int'(ov8), int'((i % 2) == 0));
            chk("gap_out", int'(out8), 0);
        end
        chk("gap_wc", int'(wc8), 3);

        // mid-frame reset discards accumulator
        cycle(1, 1, 0, 0, 4'b0001);
        cycle(0, 0, 0, 0, 4'b0000);
        cycle(1, 1, 1, 0, 4'b0011);
        chk("abort_fp", int'(fp8), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                  4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/odd_parity_checker.md
Name: odd_parity_checker

Overview:
- Registered 4-bit odd-parity checker with frame-level parity accumulation and saturating statistics counters.
- Combinational core: out = a ^ b ^ c ^ d, i.e. 1 when the 4-bit word holds an odd number of ones (a valid odd-parity word).
- Sits at the receive side of a serial/parallel link, flagging even-parity (corrupt) words to upstream control logic.

Parameters:
- CNT_W, 8, width of the word and error counters (saturating).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  1  data bit 3 (MSB)
- b  input  1  data bit 2
- c  input  1  data bit 1
- d  input  1  data bit 0 (LSB)
- in_valid  input  1  word a..d is valid this cycle
- in_last  input  1  qualified by in_valid; marks the last word of a frame
- clr  input  1  synchronous clear of counters and sticky flag
- out  output  1  registered parity of the last accepted word (1 = odd count of ones)
- out_valid  output  1  out is valid (pulses 1 cycle per accepted word)
- word_err  output  1  registered; 1 when the accepted word had even parity (out == 0)
- frame_par  output  1  XOR of all bits of all words in the completed frame
- frame_valid  output  1  1-cycle pulse when frame_par is valid
- err_sticky  output  1  set on any word_err; held until clr or reset
- word_cnt  output  CNT_W  accepted words, saturating at all-ones
- err_cnt  output  CNT_W  even-parity words, saturating at all-ones

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Reset (rst_n = 0 at an edge): out, out_valid, word_err, frame_par, frame_valid, err_sticky = 0; word_cnt, err_cnt = 0; frame accumulator = 0. Reset overrides all other inputs.
- Latency: 1 cycle. When in_valid = 1 at edge N, the following hold after edge N:
  - out = a^b^c^d.
  - out_valid = 1.
  - word_err = ~(a^b^c^d).
- When in_valid = 0: out_valid = 0 and word_err = 0; out holds its previous value.
- Frame accumulator: acc_next = acc ^ (a^b^c^d) on each accepted word.
  - When in_last = 1 with in_valid, frame_par = acc ^ (a^b^c^d) and frame_valid = 1 for one cycle, and acc returns to 0 for the next frame.
  - in_last without in_valid is ignored.
  - A single-word frame (in_last on the first word) is legal.
- Counters:
  - word_cnt increments on each accepted word.
  - err_cnt increments on each accepted word with even parity.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- err_sticky: set the cycle after an even-parity word is accepted; cleared only by clr or reset.
- clr (synchronous):
  - Zeroes word_cnt, err_cnt and err_sticky. Does not affect out, out_valid, word_err or the frame accumulator.
  - Simultaneous clr and accepted word: clear takes priority for counters and sticky; the word still produces out, out_valid and word_err. Counters read 0, not 1, after the edge.
- Reset mid-frame discards the partial frame accumulator; no frame_valid is produced for the aborted frame.
- No backpressure; the block accepts a word on every cycle in_valid is high.

Test Plan:
- Exhaustive: apply all 16 a..d combinations 0000..1111, one per cycle with in_valid = 1. Check out, one cycle later, follows 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0. Check word_err is the inverse. After the sweep, word_cnt = 16, err_cnt = 8, err_sticky = 1.
- Reset: drive rst_n = 0 for 2 cycles while in_valid = 1 and a..d = 0001 -> all outputs and counters 0. Release reset, apply 0111 -> out = 1, word_err = 0 next cycle.
- Frame: send words 0001, 0011, 0111 (last) -> frame_valid pulses once with frame_par = 1^0^1 = 0. Then single word 1000 with in_last -> frame_par = 1.
- Saturation: with CNT_W = 4, apply 20 even-parity words (0000) -> word_cnt = 15, err_cnt = 15, no wrap.
- clr collision: assert clr in the same cycle as accepting 0000 -> err_cnt = 0, word_cnt = 0, err_sticky = 0; word_err = 1 and out_valid = 1.
- Idle gaps: alternate in_valid 1/0 with 1111 -> out_valid pulses only after valid cycles, out holds 0, word_cnt counts only valid words.
